// File: rtl/memory_responder.sv
// Word-addressed memory slave with programmable wait states and a 4-phase MFC handshake.
// Latency: WAIT_CYCLES+1 edges from request acceptance to MFC; stays in DONE until Read/Write both drop.
module memory_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] Mdatain,
  output logic        MFC,
  output logic        Busy,
  output logic        Error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] mdata_q, mdata_d;
  logic        oor_q, oor_d;
  logic        conflict_q, conflict_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic        enter_done;
  logic        op_wr;
  logic [31:0] op_addr;
  logic [31:0] op_dat;
  logic        op_oor;
  logic        mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    mdata_d    = mdata_q;
    oor_d      = oor_q;
    conflict_d = 1'b0;
    err_d      = 1'b0;
    enter_done = 1'b0;
    op_wr      = wr_q;
    op_addr    = addr_q;
    op_dat     = wdat_q;

    case (state_q)
      S_IDLE: begin
        // Error fires only on the first edge of a conflict, giving a one-cycle pulse.
        conflict_d = Read & Write;
        err_d      = Read & Write & ~conflict_q;
        if (Read ^ Write) begin
          wr_d   = Write;
          addr_d = Address;
          wdat_d = DataIn;
          oor_d  = |Address[31:ADDR_W];
          cnt_d  = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
            op_wr      = Write;
            op_addr    = Address;
            op_dat     = DataIn;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        if (!Read && !Write) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    op_oor = |op_addr[31:ADDR_W];
    if (enter_done && !op_wr) begin
      mdata_d = op_oor ? 32'h0 : mem[op_addr[ADDR_W-1:0]];
    end
  end

  // Clear gating keeps a zero-wait request from writing while reset is held.
  assign mem_we = enter_done & op_wr & ~op_oor & Clear;

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[op_addr[ADDR_W-1:0]] <= op_dat;
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdat_q     <= 32'h0;
      mdata_q    <= 32'h0;
      oor_q      <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      mdata_q    <= mdata_d;
      oor_q      <= oor_d;
      conflict_q <= conflict_d;
      err_q      <= err_d;
    end
  end

  assign Mdatain = mdata_q;
  assign MFC     = (state_q == S_DONE);
  assign Busy    = (state_q != S_IDLE);
  assign Error   = err_q | ((state_q == S_DONE) & oor_q);

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: two builds of memory_responder (WAIT_CYCLES 2 and 0) driven through handshake scenarios.
module tb_memory_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Read = 1'b0, Write = 1'b0;
  logic [31:0] Address = 32'h0, DataIn = 32'h0;
  logic [31:0] Mdatain;
  logic        MFC, Busy, Error;

  logic        r1 = 1'b0, w1 = 1'b0;
  logic [31:0] a1 = 32'h0, d1 = 32'h0;
  logic [31:0] md1;
  logic        mfc1, busy1, err1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] model [512];
  logic [31:0] last_rd = 32'h0;

  always #5 Clock = ~Clock;

  memory_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(2)) dut0 (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write), .Address(Address),
    .DataIn(DataIn), .Mdatain(Mdatain), .MFC(MFC), .Busy(Busy), .Error(Error)
  );

  memory_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(0)) dut1 (
    .Clock(Clock), .Clear(Clear), .Read(r1), .Write(w1), .Address(a1),
    .DataIn(d1), .Mdatain(md1), .MFC(mfc1), .Busy(busy1), .Error(err1)
  );

  // Drives one access on dut0; after acceptance the bus inputs are scrambled to show they are ignored.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic drop,
                        output logic [46:0] obs);
    int lat;
    int mfc_len;
    logic [31:0] rd;
    logic err;
    Read = ~wr; Write = wr; Address = a; DataIn = d;
    lat = 0; mfc_len = 0;
    do begin
      @(posedge Clock); #1;
      lat++;
      if (lat == 1) begin
        Address = a ^ 32'h1;
        DataIn  = ~d;
        if (drop) begin Read = 1'b0; Write = 1'b0; end
      end
    end while (!MFC && lat < 40);
    rd  = Mdatain;
    err = Error;
    while (MFC && mfc_len < 40) begin
      mfc_len++;
      if (mfc_len == 2 || drop) begin Read = 1'b0; Write = 1'b0; end
      @(posedge Clock); #1;
    end
    Read = 1'b0; Write = 1'b0;
    obs = {8'(lat), 4'(mfc_len), Busy, Error, err, rd};
  endtask

  task automatic txn(input string name, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic drop);
    logic [46:0] obs, expv;
    exp_t e;
    logic oor;
    oor = |a[31:9];
    if (wr) begin
      sb.push_back('{data: last_rd, err: oor});
      if (!oor) model[a[8:0]] = d;
    end else begin
      sb.push_back('{data: (oor ? 32'h0 : model[a[8:0]]), err: oor});
    end
    access(wr, a, d, drop, obs);
    e = sb.pop_front();
    expv = {8'd3, (drop ? 4'd1 : 4'd2), 1'b0, 1'b0, e.err, e.data};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s {lat,mfc_len,busy,err_after,err,data} got %h want %h", name, obs, expv);
    end
    if (!wr) last_rd = e.data;
  endtask

  task automatic test_reset();
    Clear = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if ({MFC, Busy, Error, Mdatain, mfc1, busy1, err1, md1} !== 70'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h want 0", {MFC, Busy, Error, Mdatain}, {mfc1, busy1, err1, md1});
    end
    Clear = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_zero_wait();
    exp_t e;
    w1 = 1'b1; a1 = 32'h5; d1 = 32'hDEADBEEF;
    @(posedge Clock); #1;
    checks++;
    if ({mfc1, md1} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL zw_write got %h want %h", {mfc1, md1}, {1'b1, 32'h0});
    end
    w1 = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if ({mfc1, busy1} !== 2'b00) begin
      errors++; $display("FAIL zw_idle got %b want 00", {mfc1, busy1});
    end
    sb.push_back('{data: 32'hDEADBEEF, err: 1'b0});
    r1 = 1'b1;
    @(posedge Clock); #1;
    e = sb.pop_front();
    checks++;
    if ({mfc1, err1, md1} !== {1'b1, e.err, e.data}) begin
      errors++; $display("FAIL zw_read got %h want %h", {mfc1, err1, md1}, {1'b1, e.err, e.data});
    end
    r1 = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_write_read();
    txn("wr_5", 1'b1, 32'h5, 32'hDEADBEEF, 1'b0);
    txn("rd_5", 1'b0, 32'h5, 32'h0, 1'b0);
  endtask

  task automatic test_conflict();
    Read = 1'b1; Write = 1'b1; Address = 32'h5; DataIn = 32'h0;
    @(posedge Clock); #1;
    checks++;
    if ({Error, Busy, MFC} !== 3'b100) begin
      errors++; $display("FAIL conflict_pulse {err,busy,mfc} got %b want 100", {Error, Busy, MFC});
    end
    Read = 1'b0; Write = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if ({Error, Busy} !== 2'b00) begin
      errors++; $display("FAIL conflict_end {err,busy} got %b want 00", {Error, Busy});
    end
    txn("conflict_rd_5", 1'b0, 32'h5, 32'h0, 1'b0);
  endtask

  task automatic test_out_of_range();
    txn("wr_0", 1'b1, 32'h0, 32'h0BADF00D, 1'b0);
    txn("oor_rd", 1'b0, 32'h200, 32'h0, 1'b0);
    txn("oor_wr", 1'b1, 32'h200, 32'h1, 1'b0);
    txn("rd_0", 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_early_drop();
    txn("drop_rd_5", 1'b0, 32'h5, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    txn("wr_7", 1'b1, 32'h7, 32'hA5A5A5A5, 1'b0);
    txn("rd_7", 1'b0, 32'h7, 32'h0, 1'b0);
    Write = 1'b1; Address = 32'h7; DataIn = 32'h12345678;
    @(posedge Clock); #1;
    checks++;
    if ({Busy, MFC} !== 2'b10) begin
      errors++; $display("FAIL mid_wait_busy {busy,mfc} got %b want 10", {Busy, MFC});
    end
    #2 Clear = 1'b0;
    #1;
    checks++;
    if ({MFC, Busy, Error, Mdatain} !== 35'h0) begin
      errors++; $display("FAIL mid_wait_reset got %h want 0", {MFC, Busy, Error, Mdatain});
    end
    Write = 1'b0;
    #2 Clear = 1'b1;
    @(posedge Clock); #1;
    last_rd = 32'h0;
    txn("rd_7_after_abort", 1'b0, 32'h7, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'($urandom_range(0, 511));
      txn("b2b_wr", 1'b1, addrs[i], $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 7; i >= 0; i--) begin
      txn("b2b_rd", 1'b0, addrs[i], 32'h0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_write_read();
    test_conflict();
    test_out_of_range();
    test_early_drop();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning number of 32-bit words in the internal array.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning number of address bits used to index the array (2^ADDR_W = DEPTH).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0-15, meaning number of wait states inserted before completion.
REQ-004 SHALL have port Clock  input  1  system clock, all state on its rising edge.
REQ-005 SHALL have port Clear  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Read  input  1  read request from datapath, level.
REQ-007 SHALL have port Write  input  1  write request from datapath, level.
REQ-008 SHALL have port Address  input  32  word address, driven from MAR output.
REQ-009 SHALL have port DataIn  input  32  write data, driven from MDR output.
REQ-010 SHALL have port Mdatain  output  32  registered read data, feeds MDMux memory input.
REQ-011 SHALL have port MFC  output  1  memory function complete.
REQ-012 SHALL have port Busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port Error  output  1  request fault flag.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-015 SHALL, in IDLE at a rising edge with exactly one of Read/Write high, latch Address, DataIn and the operation, load the wait counter with WAIT_CYCLES, and go to WAIT (or go directly to DONE if WAIT_CYCLES = 0).
REQ-016 SHALL, in WAIT, decrement the counter each edge and go to DONE on the edge where the counter reaches 0.
REQ-017 SHALL ignore changes on Read, Write, Address and DataIn while in WAIT; the latched request always completes.
REQ-018 SHALL, on entry to DONE, perform the operation at latched Address[ADDR_W-1:0]: a write stores the latched DataIn; a read loads the array word into Mdatain in the same edge.
REQ-019 SHALL drive MFC high while in DONE and low in all other states.
REQ-020 SHALL stay in DONE until both Read and Write are low at a rising edge (4-phase handshake), then return to IDLE; a request dropped during WAIT therefore yields a one-cycle MFC pulse.
REQ-021 SHALL give a latency of WAIT_CYCLES+1 edges from the accepting edge to MFC high.
REQ-022 SHALL hold Mdatain at the last read value until the next read completes; writes do not change Mdatain.
REQ-023 SHALL treat Read and Write both high in IDLE as a fault: no access, stay IDLE, Error high for exactly one cycle.
REQ-024 SHALL treat latched Address[31:ADDR_W] nonzero as out-of-range: complete the handshake normally, suppress the write, load 0 on a read, and hold Error high for the whole of DONE.
REQ-025 SHALL keep Error low in all other cases.

Reset
REQ-026 SHALL, on Clear low, asynchronously force IDLE, counter 0, MFC 0, Busy 0, Error 0, Mdatain 0x00000000.
REQ-027 SHALL not clear array contents on reset.
REQ-028 SHALL abort any in-flight access on reset mid-WAIT: a pending write is not performed.

Verification
REQ-029 Write then read, WAIT_CYCLES=2: Write=1, Address=0x5, DataIn=0xDEADBEEF -> MFC high 3 edges later; drop Write -> IDLE; then Read=1, Address=0x5 -> Mdatain=0xDEADBEEF when MFC goes high.
REQ-030 Conflict: Read=Write=1 in IDLE -> Error pulses one cycle, Busy stays 0, the array is unchanged.
REQ-031 Out-of-range: Read with Address=0x200 -> MFC and Error high together, Mdatain=0; Write with Address=0x200, DataIn=0x1 -> word 0x000 keeps its prior value.
REQ-032 Early drop: Read asserted one cycle only, Address=0x5 -> MFC high for exactly one cycle, Mdatain=0xDEADBEEF.
REQ-033 Reset mid-WAIT: Write Address=0x7, DataIn=0x12345678, Clear low during WAIT -> outputs reset immediately, and a later read of 0x7 returns its prior value.
REQ-034 WAIT_CYCLES=0 build: Read Address=0x5 -> MFC high on the edge after acceptance, Mdatain=0xDEADBEEF.
